// File: rtl/rv_rf_pkg.sv
// Shared register-file constants and the write-back entry format used by
// the RF write-side controller and its LSU result buffer.
package rv_rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_wb_fifo.sv
// Small synchronous FIFO holding {rd, data} load results until the RF write
// port is free. Storage is not reset; only pointers and occupancy are.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rptr_q];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/rf_writeback.sv
// RF write-port controller: merges ALU results (absolute priority) with
// buffered LSU load results and keeps a pending-load scoreboard for decode.
module rf_writeback
    import rv_rf_pkg::*;
#(
    parameter int LSU_FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  alu_valid_i,
    input  logic [REG_ADDR_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]       alu_wd_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REG_ADDR_W-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]       lsu_wd_i,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    output logic                  issue_ready_o,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  hazard_o,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]       rf_wd_o,
    output logic [NUM_REGS-1:0]   pending_o
);

    wb_entry_t             lsu_in, lsu_head;
    logic                  fifo_full, fifo_empty;
    logic                  lsu_push, lsu_pop;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wd_q, rf_wd_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    assign lsu_in.rd = lsu_rd_i;
    assign lsu_in.wd = lsu_wd_i;

    // Ready depends on occupancy only: no pop-push bypass when full.
    assign lsu_ready_o = !fifo_full;
    assign lsu_push    = lsu_valid_i && lsu_ready_o;
    assign lsu_pop     = !alu_valid_i && !fifo_empty;

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset   (reset),
        .push_i  (lsu_push),
        .data_i  (lsu_in),
        .pop_i   (lsu_pop),
        .data_o  (lsu_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign issue_ready_o = !pending_q[issue_rd_i];
    assign hazard_o      = pending_q[rs1_i] | pending_q[rs2_i];

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wd_d    = rf_wd_q;
        if (alu_valid_i) begin
            rf_we_d    = (alu_rd_i != REG_ZERO);
            rf_waddr_d = alu_rd_i;
            rf_wd_d    = alu_wd_i;
        end else if (lsu_pop) begin
            rf_we_d    = (lsu_head.rd != REG_ZERO);
            rf_waddr_d = lsu_head.rd;
            rf_wd_d    = lsu_head.wd;
        end
    end

    // Clear on LSU commit first so a same-cycle issue to the same rd wins.
    always_comb begin
        pending_d = pending_q;
        if (lsu_pop && lsu_head.rd != REG_ZERO)
            pending_d[lsu_head.rd] = 1'b0;
        if (issue_valid_i && issue_ready_o && issue_rd_i != REG_ZERO)
            pending_d[issue_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wd_q    <= '0;
            pending_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wd_q    <= rf_wd_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wd_o    = rf_wd_q;
    assign pending_o  = pending_q;

endmodule
